// File: rtl/rv_mc_pkg.sv
// rv_mc_pkg
// Shared definitions for the multicycle RV32I control path:
//   - state_t        : main control FSM states
//   - instr_class_t  : instruction class fed to the ALU decoder
//   - ALU_*          : 4-bit ALU operation codes
//   - OP_*           : RV32I major opcodes handled by the core
//   - SRCA_*/SRCB_*/RES_* : datapath mux encodings
package rv_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_JALR_A,
        S_JALR_B,
        S_LUI,
        S_AUIPC,
        S_TRAP
    } state_t;

    typedef enum logic [1:0] {
        CLS_NONE,
        CLS_R,
        CLS_I,
        CLS_B
    } instr_class_t;

    // ALU operation codes
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_SLT  = 4'b0100;
    localparam logic [3:0] ALU_BLTU = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_BGEU = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_XOR  = 4'b1001;
    localparam logic [3:0] ALU_SRL  = 4'b1010;
    localparam logic [3:0] ALU_SRA  = 4'b1011;
    localparam logic [3:0] ALU_BEQ  = 4'b1100;
    localparam logic [3:0] ALU_BNE  = 4'b1101;
    localparam logic [3:0] ALU_BLT  = 4'b1110;
    localparam logic [3:0] ALU_BGE  = 4'b1111;

    // Major opcodes
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // ALU operand A select
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_REG   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    // ALU operand B select
    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Result bus select
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_MEM       = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // Class of the instruction as seen by the ALU decoder.
    function automatic instr_class_t class_of(input logic [6:0] op);
        case (op)
            OP_R:      return CLS_R;
            OP_I:      return CLS_I;
            OP_BRANCH: return CLS_B;
            default:   return CLS_NONE;
        endcase
    endfunction

endpackage

// File: rtl/rv_alu_decoder.sv
// rv_alu_decoder
// Combinational ALU operation decode from funct3/funct7b5 and instruction class.
// Ports:
//   funct3     in  3 : instruction[14:12]
//   funct7b5   in  1 : instruction[30]
//   cls        in  2 : instruction class (R, I, branch, none)
//   alu_ctrl   out 4 : ALU operation code (ADD when class is none)
//   bad_branch out 1 : branch class with an unassigned funct3 (010/011)
module rv_alu_decoder
    import rv_mc_pkg::*;
(
    input  logic [2:0]   funct3,
    input  logic         funct7b5,
    input  instr_class_t cls,
    output logic [3:0]   alu_ctrl,
    output logic         bad_branch
);

    always_comb begin
        alu_ctrl   = ALU_ADD;
        bad_branch = 1'b0;
        case (cls)
            CLS_B: begin
                case (funct3)
                    3'b000:  alu_ctrl = ALU_BEQ;
                    3'b001:  alu_ctrl = ALU_BNE;
                    3'b100:  alu_ctrl = ALU_BLT;
                    3'b101:  alu_ctrl = ALU_BGE;
                    3'b110:  alu_ctrl = ALU_BLTU;
                    3'b111:  alu_ctrl = ALU_BGEU;
                    default: bad_branch = 1'b1;
                endcase
            end
            CLS_R, CLS_I: begin
                case (funct3)
                    // Immediate forms have no SUB; bit 30 belongs to the immediate.
                    3'b000:  alu_ctrl = (cls == CLS_R && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_ctrl = ALU_SLL;
                    3'b010:  alu_ctrl = ALU_SLT;
                    3'b011:  alu_ctrl = ALU_SLTU;
                    3'b100:  alu_ctrl = ALU_XOR;
                    3'b101:  alu_ctrl = funct7b5 ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_ctrl = ALU_OR;
                    default: alu_ctrl = ALU_AND;
                endcase
            end
            default: alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/rv_mc_control.sv
// rv_mc_control
// Main control FSM of the multicycle RV32I core. Moore-decoded outputs, with
// mem_ready feeding IRWrite/PCWrite/instr_done and Comparison feeding PCWrite
// in the same cycle.
// Ports:
//   clk, rst_n            : clock (rising edge), async active-low reset
//   op, funct3, funct7b5  : registered instruction fields
//   Comparison            : ALU branch-condition result
//   mem_ready             : memory completes the current access this cycle
//   ALUCtrl               : ALU operation code
//   ALUSrcA, ALUSrcB      : ALU operand selects
//   ResultSrc, AdrSrc     : result bus and memory address selects
//   PCWrite, IRWrite, MemWrite, RegWrite : write enables
//   instr_done            : pulse in the last cycle of each instruction
//   illegal               : sticky trap flag (held until reset)
module rv_mc_control
    import rv_mc_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Comparison,
    input  logic       mem_ready,
    output logic [3:0] ALUCtrl,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       AdrSrc,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       instr_done,
    output logic       illegal
);

    state_t     state, next;
    logic [3:0] dec_ctrl;
    logic       bad_branch;
    logic       pc_write, ir_write, mem_write, reg_write, done;

    rv_alu_decoder u_alu_decoder (
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .cls        (class_of(op)),
        .alu_ctrl   (dec_ctrl),
        .bad_branch (bad_branch)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= next;
    end

    always_comb begin
        next      = state;
        ALUCtrl   = ALU_ADD;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_REG;
        ResultSrc = RES_ALUOUT;
        AdrSrc    = 1'b0;
        pc_write  = 1'b0;
        ir_write  = 1'b0;
        mem_write = 1'b0;
        reg_write = 1'b0;
        done      = 1'b0;
        case (state)
            S_FETCH: begin
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) next = S_DECODE;
            end
            S_DECODE: begin
                // Branch target is computed here and parked in ALUOut.
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (op)
                    OP_LOAD, OP_STORE: next = S_MEMADR;
                    OP_R:              next = S_EXECUTER;
                    OP_I:              next = S_EXECUTEI;
                    OP_BRANCH:         next = bad_branch ? S_TRAP : S_BRANCH;
                    OP_JAL:            next = S_JAL;
                    OP_JALR:           next = S_JALR_A;
                    OP_LUI:            next = S_LUI;
                    OP_AUIPC:          next = S_AUIPC;
                    default:           next = S_TRAP;
                endcase
                // A trapping instruction retires here.
                done = (next == S_TRAP);
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_REG;
                ALUSrcB = SRCB_IMM;
                next    = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                if (mem_ready) next = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = RES_MEM;
                reg_write = 1'b1;
                done      = 1'b1;
                next      = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc    = 1'b1;
                mem_write = 1'b1;
                done      = mem_ready;
                if (mem_ready) next = S_FETCH;
            end
            S_EXECUTER: begin
                ALUSrcA = SRCA_REG;
                ALUCtrl = dec_ctrl;
                next    = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcA = SRCA_REG;
                ALUSrcB = SRCB_IMM;
                ALUCtrl = dec_ctrl;
                next    = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                done      = 1'b1;
                next      = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA  = SRCA_REG;
                ALUCtrl  = dec_ctrl;
                pc_write = Comparison;
                done     = 1'b1;
                next     = S_FETCH;
            end
            S_JAL: begin
                // PC <- ALUOut (target); ALUOut <- OldPC + 4 for the link write.
                ALUSrcA  = SRCA_OLDPC;
                ALUSrcB  = SRCB_FOUR;
                pc_write = 1'b1;
                next     = S_ALUWB;
            end
            S_JALR_A: begin
                ALUSrcA = SRCA_REG;
                ALUSrcB = SRCB_IMM;
                next    = S_JALR_B;
            end
            S_JALR_B: begin
                ALUSrcA  = SRCA_OLDPC;
                ALUSrcB  = SRCB_FOUR;
                pc_write = 1'b1;
                next     = S_ALUWB;
            end
            S_LUI: begin
                ALUSrcA = SRCA_ZERO;
                ALUSrcB = SRCB_IMM;
                next    = S_ALUWB;
            end
            S_AUIPC: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                next    = S_ALUWB;
            end
            S_TRAP: next = S_TRAP;
            default: next = S_FETCH;
        endcase
    end

    // Reset gates the enables directly so they drop without waiting for a clock;
    // the mux selects already follow the async-reset FETCH state.
    assign PCWrite    = pc_write  & rst_n;
    assign IRWrite    = ir_write  & rst_n;
    assign MemWrite   = mem_write & rst_n;
    assign RegWrite   = reg_write & rst_n;
    assign instr_done = done      & rst_n;
    assign illegal    = (state == S_TRAP);

endmodule

// File: tb/tb_rv_mc_control.sv
// tb_rv_mc_control
// Directed bench for rv_mc_control. Each cycle the full output vector
// {ALUCtrl, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, PCWrite, IRWrite, MemWrite,
//  RegWrite, instr_done, illegal} is compared at the falling edge against a
// hand-written expected vector.
module tb_rv_mc_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Comparison;
    logic       mem_ready;
    logic [3:0] ALUCtrl;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
    logic       AdrSrc, PCWrite, IRWrite, MemWrite, RegWrite, instr_done, illegal;

    int n_checks = 0;
    int n_fail   = 0;

    rv_mc_control dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Comparison (Comparison),
        .mem_ready  (mem_ready),
        .ALUCtrl    (ALUCtrl),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .AdrSrc     (AdrSrc),
        .PCWrite    (PCWrite),
        .IRWrite    (IRWrite),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .instr_done (instr_done),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    logic [16:0] obs;
    assign obs = {ALUCtrl, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc,
                  PCWrite, IRWrite, MemWrite, RegWrite, instr_done, illegal};

    function automatic logic [16:0] sig(input int alu, input int sa, input int sb, input int rs,
                                        input int adr, input int pcw, input int irw, input int mw,
                                        input int rw, input int dn, input int ill);
        return {alu[3:0], sa[1:0], sb[1:0], rs[1:0], adr[0], pcw[0], irw[0], mw[0], rw[0], dn[0], ill[0]};
    endfunction

    // Common expected vectors (ALU code 2 = ADD)
    logic [16:0] F1, F0, RST, DEC, DEC_T, WB, TRP;

    task automatic test_reset;
        rst_n = 1'b0; mem_ready = 1'b1; Comparison = 1'b1;
        #1;
        n_checks++;
        if (obs !== RST) begin n_fail++; $display("FAIL reset_async got %05h exp %05h", obs, RST); end
        @(negedge clk);
        n_checks++;
        if (obs !== RST) begin n_fail++; $display("FAIL reset_hold got %05h exp %05h", obs, RST); end
        @(posedge clk); #1;
        rst_n = 1'b1; Comparison = 1'b0;
    endtask

    task automatic test_add;
        logic [16:0] ex [5];
        logic        mr [5];
        op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0;
        ex = '{F1, DEC, sig(2,2,0,0,0,0,0,0,0,0,0), WB, F0};
        mr = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            mem_ready = mr[i];
            @(negedge clk);
            n_checks++;
            if (obs !== ex[i]) begin n_fail++; $display("FAIL add c%0d got %05h exp %05h", i, obs, ex[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_decode;
        logic [6:0]  ops [4];
        logic [2:0]  f3s [4];
        logic        f7s [4];
        logic [16:0] exs [4];
        logic [16:0] ex  [5];
        ops = '{7'b0110011, 7'b0110011, 7'b0010011, 7'b0010011};
        f3s = '{3'b000, 3'b101, 3'b000, 3'b101};
        f7s = '{1'b1, 1'b1, 1'b1, 1'b0};
        exs = '{sig(6,2,0,0,0,0,0,0,0,0,0), sig(11,2,0,0,0,0,0,0,0,0,0),
                sig(2,2,1,0,0,0,0,0,0,0,0), sig(10,2,1,0,0,0,0,0,0,0,0)};
        for (int k = 0; k < 4; k++) begin
            op = ops[k]; funct3 = f3s[k]; funct7b5 = f7s[k];
            ex = '{F1, DEC, exs[k], WB, F0};
            for (int i = 0; i < 5; i++) begin
                mem_ready = (i != 4);
                @(negedge clk);
                n_checks++;
                if (obs !== ex[i]) begin n_fail++; $display("FAIL decode%0d c%0d got %05h exp %05h", k, i, obs, ex[i]); end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_load_stall;
        logic [16:0] ex [9];
        logic        mr [9];
        logic [16:0] MR;
        MR = sig(2,0,0,0,1,0,0,0,0,0,0);
        op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0;
        ex = '{F1, DEC, sig(2,2,1,0,0,0,0,0,0,0,0), MR, MR, MR, MR,
               sig(2,0,0,1,0,0,0,0,1,1,0), F0};
        mr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 9; i++) begin
            mem_ready = mr[i];
            @(negedge clk);
            n_checks++;
            if (obs !== ex[i]) begin n_fail++; $display("FAIL load c%0d got %05h exp %05h", i, obs, ex[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_store;
        logic [16:0] ex [6];
        logic        mr [6];
        op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0;
        // Leading FETCH stall, then a store with memory ready.
        ex = '{F0, F1, DEC, sig(2,2,1,0,0,0,0,0,0,0,0), sig(2,0,0,0,1,0,0,1,0,1,0), F0};
        mr = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            mem_ready = mr[i];
            @(negedge clk);
            n_checks++;
            if (obs !== ex[i]) begin n_fail++; $display("FAIL store c%0d got %05h exp %05h", i, obs, ex[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch;
        logic [16:0] ex [4];
        op = 7'b1100011; funct3 = 3'b001; funct7b5 = 1'b0;
        for (int c = 1; c >= 0; c--) begin
            Comparison = c[0];
            ex = '{F1, DEC, sig(13,2,0,0,0,c,0,0,0,1,0), F0};
            for (int i = 0; i < 4; i++) begin
                mem_ready = (i != 3);
                @(negedge clk);
                n_checks++;
                if (obs !== ex[i]) begin n_fail++; $display("FAIL bne_cmp%0d c%0d got %05h exp %05h", c, i, obs, ex[i]); end
                @(posedge clk); #1;
            end
        end
        Comparison = 1'b0;
    endtask

    task automatic test_jalr;
        logic [16:0] ex [6];
        op = 7'b1100111; funct3 = 3'b000; funct7b5 = 1'b0;
        ex = '{F1, DEC, sig(2,2,1,0,0,0,0,0,0,0,0), sig(2,1,2,0,0,1,0,0,0,0,0), WB, F0};
        for (int i = 0; i < 6; i++) begin
            mem_ready = (i != 5);
            @(negedge clk);
            n_checks++;
            if (obs !== ex[i]) begin n_fail++; $display("FAIL jalr c%0d got %05h exp %05h", i, obs, ex[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_jal_upper;
        logic [6:0]  ops [3];
        logic [16:0] exs [3];
        logic [16:0] ex  [5];
        ops = '{7'b1101111, 7'b0110111, 7'b0010111};
        exs = '{sig(2,1,2,0,0,1,0,0,0,0,0), sig(2,3,1,0,0,0,0,0,0,0,0), sig(2,1,1,0,0,0,0,0,0,0,0)};
        funct3 = 3'b000; funct7b5 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            op = ops[k];
            ex = '{F1, DEC, exs[k], WB, F0};
            for (int i = 0; i < 5; i++) begin
                mem_ready = (i != 4);
                @(negedge clk);
                n_checks++;
                if (obs !== ex[i]) begin n_fail++; $display("FAIL jal_upper%0d c%0d got %05h exp %05h", k, i, obs, ex[i]); end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_trap_opcode;
        op = 7'b0000000; funct3 = 3'b000; funct7b5 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            mem_ready = 1'b1;
            Comparison = i[0];
            @(negedge clk);
            n_checks++;
            if (obs !== (i == 0 ? F1 : (i == 1 ? DEC_T : TRP))) begin
                n_fail++;
                $display("FAIL trap_op c%0d got %05h exp %05h", i, obs, (i == 0 ? F1 : (i == 1 ? DEC_T : TRP)));
            end
            @(posedge clk); #1;
        end
        Comparison = 1'b0;
    endtask

    task automatic test_trap_branch;
        logic [16:0] ex [4];
        op = 7'b1100011; funct3 = 3'b010; funct7b5 = 1'b0;
        ex = '{F1, DEC_T, TRP, TRP};
        for (int i = 0; i < 4; i++) begin
            mem_ready = 1'b1;
            @(negedge clk);
            n_checks++;
            if (obs !== ex[i]) begin n_fail++; $display("FAIL trap_br c%0d got %05h exp %05h", i, obs, ex[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_midwrite;
        logic [16:0] ex [4];
        op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0;
        // MEMWRITE stalled by memory: MemWrite high, not yet done.
        ex = '{F1, DEC, sig(2,2,1,0,0,0,0,0,0,0,0), sig(2,0,0,0,1,0,0,1,0,0,0)};
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i < 3);
            @(negedge clk);
            n_checks++;
            if (obs !== ex[i]) begin n_fail++; $display("FAIL midwr c%0d got %05h exp %05h", i, obs, ex[i]); end
            if (i < 3) begin @(posedge clk); #1; end
        end
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (MemWrite !== 1'b0) begin n_fail++; $display("FAIL midwr_memwrite got %b exp 0", MemWrite); end
        n_checks++;
        if (obs !== RST) begin n_fail++; $display("FAIL midwr_rst got %05h exp %05h", obs, RST); end
        @(posedge clk); #1;
        rst_n = 1'b1; mem_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (obs !== F1) begin n_fail++; $display("FAIL midwr_restart got %05h exp %05h", obs, F1); end
        mem_ready = 1'b0;
        #1;
        n_checks++;
        if (obs !== F0) begin n_fail++; $display("FAIL midwr_fetch_stall got %05h exp %05h", obs, F0); end
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0;
        Comparison = 1'b0; mem_ready = 1'b1;
        F1    = sig(2,0,2,2,0,1,1,0,0,0,0);
        F0    = sig(2,0,2,2,0,0,0,0,0,0,0);
        RST   = sig(2,0,2,2,0,0,0,0,0,0,0);
        DEC   = sig(2,1,1,0,0,0,0,0,0,0,0);
        DEC_T = sig(2,1,1,0,0,0,0,0,0,1,0);
        WB    = sig(2,0,0,0,0,0,0,0,1,1,0);
        TRP   = sig(2,0,0,0,0,0,0,0,0,0,1);

        test_reset;
        test_add;
        test_decode;
        test_load_stall;
        test_store;
        test_branch;
        test_jalr;
        test_jal_upper;
        test_trap_opcode;
        test_reset;
        test_trap_branch;
        test_reset;
        test_reset_midwrite;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
